// File: rtl/wheel_pkg.sv
// Shared types and constants for the wheel state store and its shadow buffers.
package wheel_pkg;

   localparam int DEF_NUM_NODES      = 4;
   localparam int DEF_POSITION_SIZE  = 17;
   localparam int DEF_VELOCITY_SIZE  = 12;
   localparam int DEF_TIMEOUT_CYCLES = 4096;

   typedef logic signed [DEF_POSITION_SIZE-1:0] pos_t;
   typedef logic signed [DEF_VELOCITY_SIZE-1:0] vel_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READY   = 2'd1,
      RUNNING = 2'd2
   } wheel_state_e;

   localparam int ERR_W        = 3;
   localparam int ERR_MISMATCH = 0;
   localparam int ERR_OVERFLOW = 1;
   localparam int ERR_TIMEOUT  = 2;

endpackage

// File: rtl/wheel_shadow_buffer.sv
// Shadow buffer: sequential indexed writes, fill count, overflow flag and a
// parallel view of the contents including the sample written this cycle.
module wheel_shadow_buffer #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 34
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          clear_i,
   input  logic                          wr_i,
   input  logic [WIDTH-1:0]              wdata_i,
   output logic [$clog2(DEPTH):0]        cnt_d_o,
   output logic [DEPTH-1:0][WIDTH-1:0]   data_d_o,
   output logic                          ovf_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0]              cnt_q;
   logic [DEPTH-1:0][WIDTH-1:0] data_q;
   logic                       full;

   // Next count/contents; exposed so a same-cycle commit sees the final sample.
   always_comb begin
      full     = (cnt_q == CW'(DEPTH));
      ovf_o    = wr_i && full;
      cnt_d_o  = cnt_q;
      data_d_o = data_q;
      if (wr_i && !full) begin
         cnt_d_o = cnt_q + 1'b1;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (cnt_q == CW'(i)) data_d_o[i] = wdata_i;
         end
      end
   end

   // Register the buffer; clear only rewinds the count, stale data is never read.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         data_q <= '0;
      end else if (clear_i) begin
         cnt_q  <= '0;
      end else begin
         cnt_q  <= cnt_d_o;
         data_q <= data_d_o;
      end
   end

endmodule

// File: rtl/wheel_state_store.sv
// Committed soft-body wheel state: initial load, step launch, shadow capture of
// update_wheel results and atomic commit with sticky error reporting.
module wheel_state_store
   import wheel_pkg::*;
#(
   parameter int NUM_NODES      = DEF_NUM_NODES,
   parameter int POSITION_SIZE  = DEF_POSITION_SIZE,
   parameter int VELOCITY_SIZE  = DEF_VELOCITY_SIZE,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                                          clk_in,
   input  logic                                          rst_in,
   input  logic                                          load_valid_in,
   input  logic signed [POSITION_SIZE-1:0]               load_x_in,
   input  logic signed [POSITION_SIZE-1:0]               load_y_in,
   input  logic                                          step_in,
   input  logic signed [POSITION_SIZE-1:0]               node_in_x,
   input  logic signed [POSITION_SIZE-1:0]               node_in_y,
   input  logic                                          node_in_valid,
   input  logic signed [VELOCITY_SIZE-1:0]               velocity_in_x,
   input  logic signed [VELOCITY_SIZE-1:0]               velocity_in_y,
   input  logic                                          velocity_in_valid,
   input  logic                                          result_in,
   input  logic                                          clear_err_in,
   output logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]  nodes_out,
   output logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]  velocities_out,
   output logic                                          begin_out,
   output logic                                          state_valid_out,
   output logic                                          busy_out,
   output logic [15:0]                                   step_count_out,
   output logic [2:0]                                    error_out
);

   localparam int CW = $clog2(NUM_NODES) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   wheel_state_e                                  state_q;
   logic [CW-1:0]                                 load_cnt_q;
   logic [TW-1:0]                                 tmo_q;
   logic                                          pend_q;
   logic                                          begin_q;
   logic                                          valid_q;
   logic                                          busy_q;
   logic [15:0]                                   step_cnt_q;
   logic [ERR_W-1:0]                              err_q;
   logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]  nodes_q;
   logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]  vels_q;

   logic                                          running;
   logic                                          node_wr;
   logic                                          vel_wr;
   logic [CW-1:0]                                 node_cnt_d;
   logic [CW-1:0]                                 vel_cnt_d;
   logic                                          node_ovf;
   logic                                          vel_ovf;
   logic [NUM_NODES-1:0][2*POSITION_SIZE-1:0]     node_sh_d;
   logic [NUM_NODES-1:0][2*VELOCITY_SIZE-1:0]     vel_sh_d;
   logic                                          counts_ok;
   logic                                          commit;
   logic                                          tmo_hit;
   logic                                          leave;
   logic                                          pend_d;
   logic                                          launch;
   logic [ERR_W-1:0]                              err_set;

   assign running = (state_q == RUNNING);
   assign node_wr = running && node_in_valid;
   assign vel_wr  = running && velocity_in_valid;

   wheel_shadow_buffer #(
      .DEPTH (NUM_NODES),
      .WIDTH (2*POSITION_SIZE)
   ) u_node_buf (
      .clk_i    (clk_in),
      .rst_ni   (rst_in),
      .clear_i  (launch),
      .wr_i     (node_wr),
      .wdata_i  ({node_in_y, node_in_x}),
      .cnt_d_o  (node_cnt_d),
      .data_d_o (node_sh_d),
      .ovf_o    (node_ovf)
   );

   wheel_shadow_buffer #(
      .DEPTH (NUM_NODES),
      .WIDTH (2*VELOCITY_SIZE)
   ) u_vel_buf (
      .clk_i    (clk_in),
      .rst_ni   (rst_in),
      .clear_i  (launch),
      .wr_i     (vel_wr),
      .wdata_i  ({velocity_in_y, velocity_in_x}),
      .cnt_d_o  (vel_cnt_d),
      .data_d_o (vel_sh_d),
      .ovf_o    (vel_ovf)
   );

   // Step-end decisions; a pending request relaunches straight out of RUNNING.
   always_comb begin
      counts_ok = (node_cnt_d == CW'(NUM_NODES)) && (vel_cnt_d == CW'(NUM_NODES));
      commit    = running && result_in && counts_ok;
      tmo_hit   = running && !result_in && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
      leave     = running && (result_in || tmo_hit);
      pend_d    = pend_q || (running && step_in);
      launch    = ((state_q == READY) && step_in && !load_valid_in) || (leave && pend_d);
      err_set               = '0;
      err_set[ERR_MISMATCH] = running && result_in && !counts_ok;
      err_set[ERR_OVERFLOW] = node_ovf || vel_ovf;
      err_set[ERR_TIMEOUT]  = tmo_hit;
   end

   // Control FSM with registered outputs and committed state arrays.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= IDLE;
         load_cnt_q <= '0;
         tmo_q      <= '0;
         pend_q     <= 1'b0;
         begin_q    <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         step_cnt_q <= '0;
         err_q      <= '0;
         nodes_q    <= '0;
         vels_q     <= '0;
      end else begin
         begin_q <= launch;
         err_q   <= (clear_err_in ? '0 : err_q) | err_set;
         case (state_q)
            IDLE: begin
               if (load_valid_in) begin
                  for (int unsigned i = 0; i < NUM_NODES; i++) begin
                     if (load_cnt_q == CW'(i)) begin
                        nodes_q[0][i] <= load_x_in;
                        nodes_q[1][i] <= load_y_in;
                        vels_q[0][i]  <= '0;
                        vels_q[1][i]  <= '0;
                     end
                  end
                  if (load_cnt_q == CW'(NUM_NODES - 1)) begin
                     load_cnt_q <= '0;
                     state_q    <= READY;
                     valid_q    <= 1'b1;
                  end else begin
                     load_cnt_q <= load_cnt_q + 1'b1;
                  end
               end
            end
            READY: begin
               if (load_valid_in) begin
                  state_q    <= IDLE;
                  valid_q    <= 1'b0;
                  load_cnt_q <= '0;
               end else if (step_in) begin
                  state_q <= RUNNING;
                  busy_q  <= 1'b1;
                  tmo_q   <= '0;
               end
            end
            RUNNING: begin
               tmo_q  <= tmo_q + 1'b1;
               pend_q <= pend_d;
               if (commit) begin
                  for (int unsigned i = 0; i < NUM_NODES; i++) begin
                     nodes_q[0][i] <= node_sh_d[i][POSITION_SIZE-1:0];
                     nodes_q[1][i] <= node_sh_d[i][2*POSITION_SIZE-1:POSITION_SIZE];
                     vels_q[0][i]  <= vel_sh_d[i][VELOCITY_SIZE-1:0];
                     vels_q[1][i]  <= vel_sh_d[i][2*VELOCITY_SIZE-1:VELOCITY_SIZE];
                  end
                  step_cnt_q <= step_cnt_q + 1'b1;
               end
               if (leave) begin
                  pend_q <= 1'b0;
                  tmo_q  <= '0;
                  if (!pend_d) begin
                     state_q <= READY;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign nodes_out       = nodes_q;
   assign velocities_out  = vels_q;
   assign begin_out       = begin_q;
   assign state_valid_out = valid_q;
   assign busy_out        = busy_q;
   assign step_count_out  = step_cnt_q;
   assign error_out       = err_q;

endmodule

// File: tb/tb_wheel_state_store.sv
// Self-checking bench for wheel_state_store: vector table, directed corner
// sequences and randomized steps against a queue-based reference model.
`timescale 1ns/1ps
module tb_wheel_state_store;

   localparam int N  = 4;
   localparam int PS = 17;
   localparam int VS = 12;
   localparam int TO = 4096;

   logic                           clk_in = 1'b0;
   logic                           rst_in = 1'b1;
   logic                           load_valid_in = 1'b0;
   logic [PS-1:0]                  load_x_in = '0;
   logic [PS-1:0]                  load_y_in = '0;
   logic                           step_in = 1'b0;
   logic [PS-1:0]                  node_in_x = '0;
   logic [PS-1:0]                  node_in_y = '0;
   logic                           node_in_valid = 1'b0;
   logic [VS-1:0]                  velocity_in_x = '0;
   logic [VS-1:0]                  velocity_in_y = '0;
   logic                           velocity_in_valid = 1'b0;
   logic                           result_in = 1'b0;
   logic                           clear_err_in = 1'b0;
   logic [1:0][N-1:0][PS-1:0]      nodes_out;
   logic [1:0][N-1:0][VS-1:0]      velocities_out;
   logic                           begin_out;
   logic                           state_valid_out;
   logic                           busy_out;
   logic [15:0]                    step_count_out;
   logic [2:0]                     error_out;

   always #5 clk_in = ~clk_in;

   wheel_state_store #(
      .NUM_NODES      (N),
      .POSITION_SIZE  (PS),
      .VELOCITY_SIZE  (VS),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .load_valid_in     (load_valid_in),
      .load_x_in         (load_x_in),
      .load_y_in         (load_y_in),
      .step_in           (step_in),
      .node_in_x         (node_in_x),
      .node_in_y         (node_in_y),
      .node_in_valid     (node_in_valid),
      .velocity_in_x     (velocity_in_x),
      .velocity_in_y     (velocity_in_y),
      .velocity_in_valid (velocity_in_valid),
      .result_in         (result_in),
      .clear_err_in      (clear_err_in),
      .nodes_out         (nodes_out),
      .velocities_out    (velocities_out),
      .begin_out         (begin_out),
      .state_valid_out   (state_valid_out),
      .busy_out          (busy_out),
      .step_count_out    (step_count_out),
      .error_out         (error_out)
   );

   int checks = 0;
   int errors = 0;

   // Reference model of the committed state
   logic [PS-1:0] m_nx [N];
   logic [PS-1:0] m_ny [N];
   logic [VS-1:0] m_vx [N];
   logic [VS-1:0] m_vy [N];
   int            m_cnt = 0;
   logic [2:0]    m_err = '0;

   typedef struct {
      logic lv; int lx; int ly; logic st;
      logic sv; int i; logic res;
      logic eb; logic ev; logic ebz; int ec;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(input logic lv, input int lx, input int ly, input logic st,
                               input logic sv, input int i, input logic res,
                               input logic eb, input logic ev, input logic ebz, input int ec);
      vec_t v;
      v.lv = lv; v.lx = lx; v.ly = ly; v.st = st; v.sv = sv; v.i = i; v.res = res;
      v.eb = eb; v.ev = ev; v.ebz = ebz; v.ec = ec;
      return v;
   endfunction

   function automatic logic [PS-1:0] p17(input int v);
      return v[PS-1:0];
   endfunction

   function automatic logic [VS-1:0] v12(input int v);
      return v[VS-1:0];
   endfunction

   function automatic logic [255:0] exp_nodes();
      logic [1:0][N-1:0][PS-1:0] v;
      for (int i = 0; i < N; i++) begin
         v[0][i] = m_nx[i];
         v[1][i] = m_ny[i];
      end
      return 256'(v);
   endfunction

   function automatic logic [255:0] exp_vels();
      logic [1:0][N-1:0][VS-1:0] v;
      for (int i = 0; i < N; i++) begin
         v[0][i] = m_vx[i];
         v[1][i] = m_vy[i];
      end
      return 256'(v);
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_nodes"}, nodes_out, exp_nodes());
      check({tag, "_vels"}, velocities_out, exp_vels());
      check({tag, "_count"}, step_count_out, 256'(m_cnt % 65536));
      check({tag, "_err"}, error_out, m_err);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_nodes0"}, nodes_out, '0);
      check({tag, "_vels0"}, velocities_out, '0);
      check({tag, "_begin0"}, begin_out, '0);
      check({tag, "_valid0"}, state_valid_out, '0);
      check({tag, "_busy0"}, busy_out, '0);
      check({tag, "_count0"}, step_count_out, '0);
      check({tag, "_err0"}, error_out, '0);
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      load_valid_in = 1'b0; step_in = 1'b0; node_in_valid = 1'b0;
      velocity_in_valid = 1'b0; result_in = 1'b0; clear_err_in = 1'b0;
   endtask

   task automatic drive_sample(input logic nv, input int nx, input int ny,
                               input logic vv, input int vx, input int vy);
      node_in_valid = nv; node_in_x = p17(nx); node_in_y = p17(ny);
      velocity_in_valid = vv; velocity_in_x = v12(vx); velocity_in_y = v12(vy);
   endtask

   task automatic launch_step(input string tag);
      step_in = 1'b1;
      tick();
      check({tag, "_begin"}, begin_out, 1'b1);
      check({tag, "_busy"}, busy_out, 1'b1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lxs [N] = '{3, -2, 2, 3};
      int lys [N] = '{-2, 2, 2, -2};
      int n;
      int begins;
      logic [2*PS-1:0] qn[$];
      logic [2*VS-1:0] qv[$];

      for (int i = 0; i < N; i++) begin
         m_nx[i] = '0; m_ny[i] = '0; m_vx[i] = '0; m_vy[i] = '0;
      end

      // Asynchronous reset
      #1 rst_in = 1'b0;
      #1 check_zero("reset");
      repeat (2) @(posedge clk_in);
      #1 rst_in = 1'b1;

      // Vector table: IDLE step ignored, load, launch, stream, commit
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < N; i++)
         tbl.push_back(mk(1, lxs[i], lys[i], 0, 0, 0, 0, 0, (i == N-1), 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      for (int i = 0; i < N; i++)
         tbl.push_back(mk(0, 0, 0, 0, 1, i, 0, 0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));

      for (int k = 0; k < tbl.size(); k++) begin
         load_valid_in = tbl[k].lv;
         load_x_in = p17(tbl[k].lx);
         load_y_in = p17(tbl[k].ly);
         step_in = tbl[k].st;
         drive_sample(tbl[k].sv, tbl[k].i + 10, -tbl[k].i, tbl[k].sv, tbl[k].i, 1);
         result_in = tbl[k].res;
         tick();
         check($sformatf("row%0d_begin", k), begin_out, tbl[k].eb);
         check($sformatf("row%0d_valid", k), state_valid_out, tbl[k].ev);
         check($sformatf("row%0d_busy", k), busy_out, tbl[k].ebz);
         check($sformatf("row%0d_count", k), step_count_out, 256'(tbl[k].ec));
         if (k == N) begin
            for (int i = 0; i < N; i++) begin
               m_nx[i] = p17(lxs[i]); m_ny[i] = p17(lys[i]);
            end
            check("load_nodes", nodes_out, exp_nodes());
            check("load_vels", velocities_out, '0);
         end
      end
      for (int i = 0; i < N; i++) begin
         m_nx[i] = p17(i + 10); m_ny[i] = p17(-i); m_vx[i] = v12(i); m_vy[i] = v12(1);
      end
      m_cnt = 1;
      check_state("first_commit");

      // Final strobes in the same cycle as result_in
      launch_step("same");
      for (int i = 0; i < N; i++) begin
         drive_sample(1, i + 20, -i, 1, i + 2, 3);
         if (i == N-1) result_in = 1'b1;
         tick();
         m_nx[i] = p17(i + 20); m_ny[i] = p17(-i); m_vx[i] = v12(i + 2); m_vy[i] = v12(3);
      end
      m_cnt = 2;
      check_state("same");
      check("same_idx3_y", nodes_out[1][3], p17(-3));
      check("same_busy", busy_out, 1'b0);

      // Too few node samples: mismatch, nothing committed
      launch_step("short");
      for (int i = 0; i < N; i++) begin
         drive_sample(i < 3, 99, 99, 1, 77, 77);
         tick();
      end
      result_in = 1'b1;
      tick();
      m_err = 3'b001;
      check_state("short");
      check("short_busy", busy_out, 1'b0);
      check("short_valid", state_valid_out, 1'b1);
      clear_err_in = 1'b1;
      tick();
      m_err = '0;
      check("short_clear", error_out, m_err);

      // Five node samples: overflow flagged, fifth dropped, first four commit
      launch_step("ovf");
      for (int i = 0; i < 5; i++) begin
         drive_sample(1, 30 + i, 40 + i, i < N, 50 + i, -i);
         tick();
      end
      check("ovf_flag", error_out, 3'b010);
      result_in = 1'b1;
      tick();
      for (int i = 0; i < N; i++) begin
         m_nx[i] = p17(30 + i); m_ny[i] = p17(40 + i); m_vx[i] = v12(50 + i); m_vy[i] = v12(-i);
      end
      m_cnt = 3;
      m_err = 3'b010;
      check_state("ovf");
      clear_err_in = 1'b1;
      tick();
      m_err = '0;

      // Timeout
      launch_step("tmo");
      n = TO + 101;
      for (int c = 1; c <= TO + 100; c++) begin
         tick();
         if (error_out[2]) begin
            n = c;
            break;
         end
      end
      check("tmo_cycles", 256'(n), 256'(TO));
      check("tmo_busy", busy_out, 1'b0);
      m_err = 3'b100;
      check_state("tmo");
      clear_err_in = 1'b1;
      tick();
      m_err = '0;

      // Pending step: two requests merge into one relaunch after commit
      launch_step("pend");
      begins = 0;
      for (int i = 0; i < N; i++) begin
         step_in = (i < 2);
         drive_sample(1, 60 + i, 61 + i, 1, 62 + i, 63 + i);
         tick();
         begins += int'(begin_out);
         m_nx[i] = p17(60 + i); m_ny[i] = p17(61 + i); m_vx[i] = v12(62 + i); m_vy[i] = v12(63 + i);
      end
      result_in = 1'b1;
      tick();
      begins += int'(begin_out);
      m_cnt = 4;
      check("pend_begin", begin_out, 1'b1);
      check("pend_busy", busy_out, 1'b1);
      check_state("pend");
      for (int i = 0; i < N; i++) begin
         drive_sample(1, 70 + i, 71 + i, 1, 72 + i, 73 + i);
         tick();
         begins += int'(begin_out);
         m_nx[i] = p17(70 + i); m_ny[i] = p17(71 + i); m_vx[i] = v12(72 + i); m_vy[i] = v12(73 + i);
      end
      result_in = 1'b1;
      tick();
      begins += int'(begin_out);
      tick();
      begins += int'(begin_out);
      m_cnt = 5;
      check("pend_begins", 256'(begins), 256'(1));
      check("pend_done_busy", busy_out, 1'b0);
      check_state("pend2");

      // Reset in the middle of a step, then a stale result_in
      launch_step("rst");
      drive_sample(1, 1, 1, 1, 1, 1);
      tick();
      #2 rst_in = 1'b0;
      #1 check_zero("midrst");
      repeat (2) @(posedge clk_in);
      #1 rst_in = 1'b1;
      result_in = 1'b1;
      tick();
      tick();
      check_zero("late_result");
      for (int i = 0; i < N; i++) begin
         m_nx[i] = '0; m_ny[i] = '0; m_vx[i] = '0; m_vy[i] = '0;
      end
      m_cnt = 0;
      m_err = '0;

      // Randomized: fresh load, then steps with random sample counts and timing
      for (int i = 0; i < N; i++) begin
         load_valid_in = 1'b1;
         load_x_in = PS'($urandom);
         load_y_in = PS'($urandom);
         m_nx[i] = load_x_in; m_ny[i] = load_y_in;
         tick();
      end
      check("rnd_load_valid", state_valid_out, 1'b1);
      check_state("rnd_load");

      for (int s = 0; s < 30; s++) begin
         int counts [5] = '{3, 4, 4, 4, 5};
         int rem_n, rem_v, guard;
         logic same, ovf, nv, vv;
         rem_n = counts[$urandom_range(0, 4)];
         rem_v = counts[$urandom_range(0, 4)];
         same = 1'($urandom_range(0, 1));
         ovf = 1'b0;
         guard = 0;
         qn.delete();
         qv.delete();
         launch_step($sformatf("rnd%0d", s));
         while (rem_n > 0 || rem_v > 0) begin
            guard++;
            nv = (rem_n > 0) && (guard > 20 || $urandom_range(0, 2) != 0);
            vv = (rem_v > 0) && (guard > 20 || $urandom_range(0, 2) != 0);
            node_in_valid = nv;
            node_in_x = PS'($urandom); node_in_y = PS'($urandom);
            velocity_in_valid = vv;
            velocity_in_x = VS'($urandom); velocity_in_y = VS'($urandom);
            if (nv) begin
               if (qn.size() < N) qn.push_back({node_in_y, node_in_x});
               else ovf = 1'b1;
               rem_n--;
            end
            if (vv) begin
               if (qv.size() < N) qv.push_back({velocity_in_y, velocity_in_x});
               else ovf = 1'b1;
               rem_v--;
            end
            if (rem_n == 0 && rem_v == 0 && same) result_in = 1'b1;
            tick();
         end
         if (!same) begin
            result_in = 1'b1;
            tick();
         end
         if (qn.size() == N && qv.size() == N) begin
            for (int i = 0; i < N; i++) begin
               {m_ny[i], m_nx[i]} = qn[i];
               {m_vy[i], m_vx[i]} = qv[i];
            end
            m_cnt++;
         end else begin
            m_err[0] = 1'b1;
         end
         if (ovf) m_err[1] = 1'b1;
         check_state($sformatf("rnd%0d", s));
         check($sformatf("rnd%0d_idle", s), busy_out, 1'b0);
         if (m_err != 0) begin
            clear_err_in = 1'b1;
            tick();
            m_err = '0;
            check($sformatf("rnd%0d_clear", s), error_out, m_err);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wheel_state_store.md
Name: wheel_state_store

Overview:
- Downstream stage of update_wheel: captures its streamed node/velocity results into a shadow buffer and commits them atomically on result_in.
- Holds the committed soft-body wheel state and drives it back into update_wheel's nodes_in/velocities_in.
- Issues begin_out for the next physics step when step_in (frame tick) arrives.
- Also accepts the initial node positions through a load stream.

Parameters:
- NUM_NODES, 4, wheel nodes per step
- POSITION_SIZE, 17, signed node coordinate width
- VELOCITY_SIZE, 12, signed velocity width
- TIMEOUT_CYCLES, 4096, max cycles from begin_out to result_in

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous reset, active-low
- load_valid_in  in  1  initial-node stream strobe
- load_x_in, load_y_in  in  POSITION_SIZE each  signed initial node position
- step_in  in  1  request one physics step
- node_in_x, node_in_y  in  POSITION_SIZE each  from update_wheel node_out_x/y
- node_in_valid  in  1  from node_out_valid
- velocity_in_x, velocity_in_y  in  VELOCITY_SIZE each  from velocity_out_x/y
- velocity_in_valid  in  1  from velocity_out_valid
- result_in  in  1  from update_wheel result_out
- clear_err_in  in  1  clears error_out
- nodes_out  out  [1:0][NUM_NODES] x POSITION_SIZE  committed positions ([0]=x, [1]=y)
- velocities_out  out  [1:0][NUM_NODES] x VELOCITY_SIZE  committed velocities
- begin_out  out  1  one-cycle start pulse to update_wheel begin_in
- state_valid_out  out  1  committed state is valid
- busy_out  out  1  step in flight
- step_count_out  out  16  committed steps, wraps
- error_out  out  3  sticky: [0] count mismatch, [1] overflow, [2] timeout

Behaviour:
- Reset (async, rst_in=0): all outputs 0; arrays 0; counters 0; pending flag 0; state IDLE.
- FSM state IDLE: each load_valid_in writes load_x/y into node[load_cnt] and sets velocity[load_cnt]=0.
  - After NUM_NODES loads, go to READY and assert state_valid_out the next cycle.
  - step_in in IDLE is ignored.
- FSM state READY: load_valid_in restarts loading (load_cnt=0, back to IDLE, state_valid_out=0).
- Step launch: step_in in READY gives begin_out=1 the next cycle, one cycle only. Then RUNNING, busy_out=1; shadow counters and timeout counter clear.
- FSM state RUNNING, collection: node_in_valid writes shadow_node[node_cnt] and increments node_cnt. Velocity stream works the same with an independent counter. Both strobes in the same cycle is legal.
- Overflow: a valid strobe with count==NUM_NODES is dropped and sets error_out[1].
- Commit: result_in in RUNNING with node_cnt==vel_cnt==NUM_NODES copies the shadow buffers to nodes_out/velocities_out for every index. Values are visible the cycle after result_in. step_count_out increments. State goes to READY.
- result_in in the same cycle as the final valid strobe: that sample is included, so the count test uses the post-increment value.
- Count mismatch: result_in with either count != NUM_NODES sets error_out[0], discards the shadow buffer (committed state unchanged) and returns to READY.
- Timeout: the timeout counter reaches TIMEOUT_CYCLES in RUNNING → set error_out[2], discard, return to READY.
- Pending step: step_in during RUNNING sets a one-deep pending flag; extra requests merge. On return to READY with pending set, begin_out pulses the cycle after commit and pending clears.
- Ignored inputs: valid strobes and result_in outside RUNNING; load_valid_in in RUNNING.
- Errors: clear_err_in zeroes error_out. A same-cycle set wins over clear.
- Reset mid-step: everything clears; a late result_in in IDLE is ignored.
- Widths: no arithmetic on the data; counters are $clog2(NUM_NODES)+1 bits; step_count wraps 0xFFFF→0.

Decomposition:
- Shared package wheel_pkg holds:
  - pos_t/vel_t signed typedefs derived from POSITION_SIZE/VELOCITY_SIZE
  - the FSM state enum (IDLE, READY, RUNNING)
  - error bit index constants
- One sub-module, wheel_shadow_buffer: indexed write port, count, overflow flag, parallel read. Instantiated twice, once for positions and once for velocities.

Test Plan:
- Load (3,-2),(-2,2),(2,2),(3,-2) → state_valid_out=1 one cycle after 4th load; nodes_out matches; velocities_out all 0.
- step_in → begin_out high exactly one cycle. Stream 4 nodes x=i+10, y=-i and velocities (i,1), then result_in → nodes_out/velocities_out updated next cycle, step_count_out=1, error_out=0.
- Final node/velocity valid in the same cycle as result_in → commit succeeds with index 3 correct (node[3] y = -3, not another index's value).
- Only 3 node strobes then result_in → error_out=3'b001, nodes_out unchanged, back in READY. clear_err_in → error_out=0.
- 5 node strobes → error_out[1]=1, fifth sample absent. No result_in for 4096 cycles → error_out[2]=1, busy_out=0.
- Two step_in pulses during RUNNING → exactly one begin_out, one cycle after commit. rst_in low mid-RUNNING → all outputs 0 immediately; later result_in has no effect.
